// File: rtl/clk_gate_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : clk_gate_ctrl_if
// Brief    : Idle/wake status and 4-phase quiesce handshake between the
//            clock-gate controller and the gated domain.
// Revision : 1.0
// ============================================================================
interface clk_gate_ctrl_if;
    logic gate_allow_i;
    logic busy_i;
    logic wake_req_i;
    logic gate_ack_i;
    logic gate_req_o;
    logic en_o;
    logic gated_o;
    logic wake_done_o;

    // Controller side.
    modport master (
        input  gate_allow_i,
        input  busy_i,
        input  wake_req_i,
        input  gate_ack_i,
        output gate_req_o,
        output en_o,
        output gated_o,
        output wake_done_o
    );

    // Gated domain / power manager side.
    modport slave (
        output gate_allow_i,
        output busy_i,
        output wake_req_i,
        output gate_ack_i,
        input  gate_req_o,
        input  en_o,
        input  gated_o,
        input  wake_done_o
    );
endinterface
`default_nettype wire

// File: rtl/clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_gate_ctrl
// Brief    : Always-on enable controller for a clock gate: idle detection,
//            4-phase quiesce handshake, gating and wake with settle time.
//            Optional gated-cycle statistics with CLK_GATE_CTRL_STATS_EN.
// Revision : 1.0
// ============================================================================
module clk_gate_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
`ifdef CLK_GATE_CTRL_STATS_EN
    input  logic               stats_clr_i,
    output logic [31:0]        gated_cycles_o,
`endif
    clk_gate_ctrl_if.master    gif
);

    typedef enum logic [2:0] {
        S_RUN       = 3'd0,
        S_IDLE_WAIT = 3'd1,
        S_REQ       = 3'd2,
        S_GATED     = 3'd3,
        S_WAKE      = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] c_IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_WAKE_SAT  = CNT_W'(WAKE_CYCLES);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               en_q;
    logic               req_q;
    logic               gated_q;
    logic               done_q;
    logic               w_idle;

    assign w_idle = gif.gate_allow_i & ~gif.busy_i & ~gif.wake_req_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            en_q    <= 1'b1;
            req_q   <= 1'b0;
            gated_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_RUN: begin
                    if (w_idle) begin
                        if (IDLE_CYCLES == 1) begin
                            state_q <= S_REQ;
                            req_q   <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= S_IDLE_WAIT;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                end
                S_IDLE_WAIT: begin
                    if (!w_idle) begin
                        state_q <= S_RUN;
                        cnt_q   <= '0;
                    end else if (cnt_q == c_IDLE_LAST) begin
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                S_REQ: begin
                    // A coincident ack loses to a fresh wake/busy: never gate a domain that is needed.
                    if (!w_idle) begin
                        state_q <= S_RUN;
                        req_q   <= 1'b0;
                        cnt_q   <= '0;
                    end else if (gif.gate_ack_i) begin
                        state_q <= S_GATED;
                        en_q    <= 1'b0;
                        gated_q <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                S_GATED: begin
                    if (gif.wake_req_i || !gif.gate_allow_i) begin
                        state_q <= S_WAKE;
                        en_q    <= 1'b1;
                        gated_q <= 1'b0;
                        req_q   <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                S_WAKE: begin
                    // Clock stays enabled until the domain has dropped its ack.
                    if ((cnt_q >= c_WAKE_LAST) && !gif.gate_ack_i) begin
                        state_q <= S_RUN;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else if (cnt_q < c_WAKE_SAT) begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_RUN;
                    cnt_q   <= '0;
                    en_q    <= 1'b1;
                    req_q   <= 1'b0;
                    gated_q <= 1'b0;
                end
            endcase
        end
    end

    assign gif.en_o        = en_q;
    assign gif.gate_req_o  = req_q;
    assign gif.gated_o     = gated_q;
    assign gif.wake_done_o = done_q;

`ifdef CLK_GATE_CTRL_STATS_EN
    logic [31:0] gated_cycles_q;
    logic [31:0] gated_cycles_d;

    always_comb begin
        gated_cycles_d = gated_cycles_q;
        if (stats_clr_i) begin
            gated_cycles_d = '0;
        end else if ((state_q == S_GATED) && (gated_cycles_q != 32'hFFFF_FFFF)) begin
            gated_cycles_d = gated_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gated_cycles_q <= '0;
        end else begin
            gated_cycles_q <= gated_cycles_d;
        end
    end

    assign gated_cycles_o = gated_cycles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_gate_ctrl
// Brief    : Two controllers (IDLE=16/WAKE=2 and IDLE=1/WAKE=3) driven by
//            directed then random stimulus, checked against a mode model.
// Revision : 1.0
// ============================================================================
module tb_clk_gate_ctrl;
    localparam int IC0 = 16, WC0 = 2, IC1 = 1, WC1 = 3;

    logic clk = 1'b0;
    logic rst, allow, busy, wake, clr;
    logic [1:0] ack;
    always #5 clk = ~clk;

    clk_gate_ctrl_if if0();
    clk_gate_ctrl_if if1();
    assign if0.gate_allow_i = allow;
    assign if0.busy_i       = busy;
    assign if0.wake_req_i   = wake;
    assign if0.gate_ack_i   = ack[0];
    assign if1.gate_allow_i = allow;
    assign if1.busy_i       = busy;
    assign if1.wake_req_i   = wake;
    assign if1.gate_ack_i   = ack[1];

    logic [31:0] gc [2];
`ifndef CLK_GATE_CTRL_STATS_EN
    assign gc[0] = '0;
    assign gc[1] = '0;
`endif

    clk_gate_ctrl #(.IDLE_CYCLES(IC0), .WAKE_CYCLES(WC0), .CNT_W(8)) u_dut0 (
        .clk_i          (clk),
        .rst_i          (rst),
`ifdef CLK_GATE_CTRL_STATS_EN
        .stats_clr_i    (clr),
        .gated_cycles_o (gc[0]),
`endif
        .gif            (if0)
    );

    clk_gate_ctrl #(.IDLE_CYCLES(IC1), .WAKE_CYCLES(WC1), .CNT_W(8)) u_dut1 (
        .clk_i          (clk),
        .rst_i          (rst),
`ifdef CLK_GATE_CTRL_STATS_EN
        .stats_clr_i    (clr),
        .gated_cycles_o (gc[1]),
`endif
        .gif            (if1)
    );

    logic [1:0] d_req, d_en, d_gated, d_done;
    assign d_req   = {if1.gate_req_o,  if0.gate_req_o};
    assign d_en    = {if1.en_o,        if0.en_o};
    assign d_gated = {if1.gated_o,     if0.gated_o};
    assign d_done  = {if1.wake_done_o, if0.wake_done_o};

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Mode model: 0 running (incl. counting idle), 1 requesting, 2 gated, 3 waking.
    int     m_mode [2] = '{0, 0};
    int     m_run  [2] = '{0, 0};
    int     m_age  [2] = '{0, 0};
    bit     m_done [2] = '{0, 0};
    longint m_stats[2] = '{0, 0};
    int     m_ic   [2] = '{IC0, IC1};
    int     m_wc   [2] = '{WC0, WC1};
    int     cyc = 0;

    always @(posedge clk) begin
        bit idle;
        if (rst) cyc = 0; else cyc++;
        idle = allow && !busy && !wake;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_mode[k] = 0; m_run[k] = 0; m_age[k] = 0; m_done[k] = 0; m_stats[k] = 0;
            end else begin
                m_done[k] = 0;
                if (clr) m_stats[k] = 0;
                else if (m_mode[k] == 2 && m_stats[k] < 64'hFFFF_FFFF) m_stats[k]++;
                case (m_mode[k])
                    0: if (idle) begin
                           m_run[k]++;
                           if (m_run[k] >= m_ic[k]) begin m_mode[k] = 1; m_run[k] = 0; end
                       end else m_run[k] = 0;
                    1: if (!idle) m_mode[k] = 0;
                       else if (ack[k]) m_mode[k] = 2;
                    2: if (wake || !allow) begin m_mode[k] = 3; m_age[k] = 0; end
                    default: if (m_age[k] + 1 >= m_wc[k] && !ack[k]) begin
                                 m_mode[k] = 0; m_done[k] = 1;
                             end else m_age[k]++;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check($sformatf("dut%0d_gate_req", k), d_req[k],   (m_mode[k] == 1 || m_mode[k] == 2));
            check($sformatf("dut%0d_en",       k), d_en[k],    (m_mode[k] != 2));
            check($sformatf("dut%0d_gated",    k), d_gated[k], (m_mode[k] == 2));
            check($sformatf("dut%0d_wake_done",k), d_done[k],  m_done[k]);
`ifdef CLK_GATE_CTRL_STATS_EN
            check($sformatf("dut%0d_gated_cycles", k), gc[k], m_stats[k]);
`endif
        end
    end

    // Gated-domain responder: raises/drops ack some cycles after req changes.
    bit auto_ack[2] = '{1, 1};
    bit rnd_dly = 0;
    int rc[2] = '{0, 0};
    int rise_d[2] = '{3, 3};
    int fall_d[2] = '{2, 2};

    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (auto_ack[k]) begin
                if (d_req[k] && !ack[k]) begin
                    rc[k]++;
                    if (rc[k] >= rise_d[k]) begin
                        ack[k] = 1'b1; rc[k] = 0;
                        if (rnd_dly) rise_d[k] = $urandom_range(1, 4);
                    end
                end else if (!d_req[k] && ack[k]) begin
                    rc[k]++;
                    if (rc[k] >= fall_d[k]) begin
                        ack[k] = 1'b0; rc[k] = 0;
                        if (rnd_dly) fall_d[k] = $urandom_range(1, 8);
                    end
                end else rc[k] = 0;
                if (rnd_dly && $urandom_range(0, 299) == 0) ack[k] = ~ack[k];
            end
        end
    endtask

    int t_req, t_enl, t1_req, t_enh, t_done, n_done, n_req;

    initial begin
        rst = 1'b1; allow = 1'b0; busy = 1'b0; wake = 1'b0; clr = 1'b0; ack = 2'b00;
        repeat (3) tick();
        check("reset_en", d_en[0], 1);
        check("reset_gate_req", d_req[0], 0);
        check("reset_gated", d_gated[0], 0);
        rst = 1'b0; allow = 1'b1;

        // Continuous idle from cycle 0, ack 2 cycles after req.
        t_req = -1; t_enl = -1; t1_req = -1;
        while (cyc < 30) begin
            tick();
            if (d_req[0] && t_req < 0) t_req = cyc;
            if (!d_en[0] && t_enl < 0) t_enl = cyc;
            if (d_req[1] && t1_req < 0) t1_req = cyc;
        end
        check("req_rise_cycle", t_req, 16);
        check("en_fall_cycle", t_enl, 19);
        check("idle1_req_rise_cycle", t1_req, 1);
        check("gated_status", d_gated[0], 1);

        // Wake held: en returns next cycle, single done pulse, no re-gating.
        wake = 1'b1;
        t_enh = -1; t_done = -1; n_done = 0; n_req = 0;
        while (cyc < 45) begin
            tick();
            if (d_en[0] && t_enh < 0) t_enh = cyc;
            if (d_done[0]) begin n_done++; if (t_done < 0) t_done = cyc; end
            if (d_req[0]) n_req++;
        end
        check("wake_en_rise_cycle", t_enh, 31);
        check("wake_done_cycle", t_done, 33);
        check("wake_done_pulses", n_done, 1);
        check("regate_while_wake", n_req, 0);
        wake = 1'b0;

        // Ack and wake arrive together while requesting: abort wins.
        auto_ack[0] = 0;
        t_req = -1;
        while (cyc < 61) begin
            tick();
            if (d_req[0] && t_req < 0) t_req = cyc;
        end
        check("req_after_wake_cycle", t_req, 61);
        wake = 1'b1; ack[0] = 1'b1;
        tick();
        check("abort_gate_req", d_req[0], 0);
        check("abort_en", d_en[0], 1);
        check("abort_gated", d_gated[0], 0);
        wake = 1'b0; ack[0] = 1'b0; auto_ack[0] = 1;

        // Busy at idle sample 10 restarts the idle count.
        t_req = -1;
        while (cyc < 71) begin
            tick();
            if (d_req[0] && t_req < 0) t_req = cyc;
        end
        busy = 1'b1;
        tick();
        if (d_req[0] && t_req < 0) t_req = cyc;
        busy = 1'b0;
        while (cyc < 90) begin
            tick();
            if (d_req[0] && t_req < 0) t_req = cyc;
        end
        check("req_after_busy_cycle", t_req, 88);

        // Reset while gated.
        while (cyc < 95) tick();
        check("gated_before_reset", d_gated[0], 1);
        rst = 1'b1;
        tick();
        check("rst_gated_en", d_en[0], 1);
        check("rst_gated_req", d_req[0], 0);
        check("rst_gated_gated", d_gated[0], 0);
        rst = 1'b0;

        // Gate for exactly 50 cycles, then clear during an increment.
        while (cyc < 68) tick();
        wake = 1'b1;
        tick();
        tick();
`ifdef CLK_GATE_CTRL_STATS_EN
        check("gated_cycles_50", gc[0], 50);
`endif
        wake = 1'b0;
        while (cyc < 93) tick();
        check("gated_before_clr", d_gated[0], 1);
        clr = 1'b1;
        tick();
`ifdef CLK_GATE_CTRL_STATS_EN
        check("gated_cycles_clr", gc[0], 0);
`endif
        clr = 1'b0;
        tick();
`ifdef CLK_GATE_CTRL_STATS_EN
        check("gated_cycles_after_clr", gc[0], 1);
`endif

        // Ack stuck high in wake: clock must stay enabled.
        auto_ack[0] = 0;
        wake = 1'b1;
        n_done = 0;
        while (cyc < 115) begin
            tick();
            if (d_done[0]) n_done++;
        end
        check("stuck_ack_en", d_en[0], 1);
        check("stuck_ack_no_done", n_done, 0);
        ack[0] = 1'b0; auto_ack[0] = 1; wake = 1'b0;

        // Randomised traffic, alternating quiet and noisy windows.
        rnd_dly = 1;
        for (int i = 0; i < 3000; i++) begin
            bit quiet;
            quiet = ((i / 200) % 2) == 0;
            tick();
            allow = ($urandom_range(0, 31) != 0);
            busy  = quiet ? ($urandom_range(0, 63) == 0) : ($urandom_range(0, 3) == 0);
            wake  = quiet ? ($urandom_range(0, 79) == 0) : ($urandom_range(0, 9) == 0);
            clr   = ($urandom_range(0, 99) == 0);
            rst   = ($urandom_range(0, 699) == 0);
        end
        rst = 1'b0; busy = 1'b1; wake = 1'b0; clr = 1'b0;
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
